// File: rtl/dac_spi_responder_if.sv
// SPI pin bundle between the DAC master and the DAC responder model.
interface dac_spi_responder_if;
  logic sck;
  logic ss_L;
  logic mosi;
  logic miso;

  modport master (output sck, output ss_L, output mosi, input miso);
  modport slave  (input sck, input ss_L, input mosi, output miso);
endinterface

// File: rtl/dac_spi_responder.sv
// SPI slave modelling a 24-bit DAC: write frames load DAC/control registers,
// read commands are answered on the following frame. Runs in the clk domain.
module dac_spi_responder #(
  parameter int WID           = 24,
  parameter int WID_LEN       = 5,
  parameter int DATA_WID      = 20,
  parameter int ADDR_WID      = 3,
  parameter bit POLARITY      = 1'b0,
  parameter bit PHASE         = 1'b1,
  parameter int SYNC_STAGES   = 2,
  parameter int DAC_RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  dac_spi_responder_if.slave  spi,
  output logic [DATA_WID-1:0] dac_value,
  output logic [DATA_WID-1:0] ctrl_value,
  output logic                frame_done,
  output logic                frame_err
);

  typedef enum logic [1:0] {RESYNC, READY, SHIFT, COMMIT} state_t;

  localparam logic [WID_LEN-1:0]  CNT_FULL  = WID_LEN'(WID);
  localparam logic [WID_LEN-1:0]  CNT_MAX   = WID_LEN'(WID + 1);
  localparam logic [ADDR_WID-1:0] ADDR_DAC  = ADDR_WID'(1);
  localparam logic [ADDR_WID-1:0] ADDR_CTRL = ADDR_WID'(2);

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_prev;

  state_t              state;
  logic [WID_LEN-1:0]  bit_cnt;
  logic [WID-1:0]      rx_shift, tx_shift;
  logic                pending_read;
  logic [ADDR_WID-1:0] pending_addr;
  logic                miso_r;

  logic                sck_s, ss_s, mosi_s;
  logic                lead_edge, trail_edge, sample_edge, drive_edge;
  logic [DATA_WID-1:0] rd_data;
  logic [WID-1:0]      tx_load;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = (sck_s != sck_prev) && (sck_s != POLARITY);
  assign trail_edge  = (sck_s != sck_prev) && (sck_s == POLARITY);
  assign sample_edge = PHASE ? trail_edge : lead_edge;
  assign drive_edge  = PHASE ? lead_edge  : trail_edge;

  assign spi.miso = miso_r;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (pending_addr)
      ADDR_DAC:  rd_data = dac_value;
      ADDR_CTRL: rd_data = ctrl_value;
      default:   rd_data = '0;
    endcase
  end

  assign tx_load = pending_read ? {1'b1, pending_addr, rd_data} : '0;

  // NOTE: ss_L synchronizer resets to 0 (selected) so RESYNC waits for a real
  // deselect from the pin rather than trusting the reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= {SYNC_STAGES{POLARITY}};
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= POLARITY;
    end else begin
      sck_sync  <= (sck_sync << 1)  | SYNC_STAGES'(spi.sck);
      ss_sync   <= (ss_sync << 1)   | SYNC_STAGES'(spi.ss_L);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi.mosi);
      sck_prev  <= sck_s;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every read
  // below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESYNC;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      pending_read <= 1'b0;
      pending_addr <= '0;
      miso_r       <= 1'b0;
      dac_value    <= DATA_WID'(DAC_RESET_VAL);
      ctrl_value   <= '0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RESYNC: begin
          miso_r <= 1'b0;
          if (ss_s) state <= READY;
        end

        READY: begin
          miso_r <= 1'b0;
          if (!ss_s) begin
            bit_cnt <= '0;
            state   <= SHIFT;
            // Mode 0 presents the MSB before the first clock edge.
            if (PHASE) begin
              tx_shift <= tx_load;
            end else begin
              miso_r   <= tx_load[WID-1];
              tx_shift <= tx_load << 1;
            end
          end
        end

        SHIFT: begin
          if (ss_s) begin
            state <= COMMIT;
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[WID-2:0], mosi_s};
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
            end
            if (drive_edge) begin
              miso_r   <= tx_shift[WID-1];
              tx_shift <= tx_shift << 1;
            end
          end
        end

        COMMIT: begin
          miso_r <= 1'b0;
          state  <= READY;
          if (bit_cnt == CNT_FULL) begin
            frame_done   <= 1'b1;
            pending_read <= 1'b0;
            if (rx_shift[WID-1]) begin
              pending_read <= 1'b1;
              pending_addr <= rx_shift[DATA_WID +: ADDR_WID];
            end else begin
              case (rx_shift[DATA_WID +: ADDR_WID])
                ADDR_DAC:  dac_value  <= rx_shift[DATA_WID-1:0];
                ADDR_CTRL: ctrl_value <= rx_shift[DATA_WID-1:0];
                default:   ;
              endcase
            end
          end else if (bit_cnt != '0) begin
            frame_err <= 1'b1;
          end
        end

        default: state <= RESYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_responder.sv
// Scoreboard bench for dac_spi_responder: one DUT per SPI mode, a bit-banged
// master on the selected one, and a monitor that checks every frame pulse.
module tb_dac_spi_responder;

  localparam int HALF = 10;

  typedef struct {
    bit          err;
    bit          chk_miso;
    logic [23:0] miso;
    logic [19:0] dac;
    logic [19:0] ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   mode;
  logic sck_drv, ss_drv, mosi_drv;

  logic        miso_v [4];
  logic [19:0] dac_v  [4];
  logic [19:0] ctrl_v [4];
  logic        done_v [4];
  logic        err_v  [4];

  exp_t        sb[$];
  logic [23:0] cap_word;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Mode k: 0 = POL0/PHA1, 1 = POL0/PHA0, 2 = POL1/PHA0, 3 = POL1/PHA1.
  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam bit POL = (k >= 2);
    localparam bit PHA = (k == 0) || (k == 3);

    dac_spi_responder_if bus ();

    assign bus.sck  = (mode == k) ? sck_drv : POL;
    assign bus.ss_L = (mode == k) ? ss_drv  : 1'b1;
    assign bus.mosi = mosi_drv;
    assign miso_v[k] = bus.miso;

    dac_spi_responder #(.POLARITY(POL), .PHASE(PHA)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .spi        (bus),
      .dac_value  (dac_v[k]),
      .ctrl_value (ctrl_v[k]),
      .frame_done (done_v[k]),
      .frame_err  (err_v[k])
    );
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  // Monitor: every frame pulse on the active DUT consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (done_v[mode] || err_v[mode])) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b with empty scoreboard",
                 done_v[mode], err_v[mode]);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_done", 24'(done_v[mode]), 24'(!e.err));
        check("frame_err",  24'(err_v[mode]),  24'(e.err));
        check("dac_value",  24'(dac_v[mode]),  24'(e.dac));
        check("ctrl_value", 24'(ctrl_v[mode]), 24'(e.ctrl));
        if (e.chk_miso) check("miso_word", cap_word, e.miso);
      end
    end
  end

  // Bit-bang one frame on DUT m; nbits may be short or long, rst_at pulses rst at that bit.
  task automatic spi_frame(input int m, input logic [23:0] word, input int nbits,
                           input int rst_at, input bit push, input bit exp_err,
                           input bit chk_miso, input logic [23:0] exp_miso,
                           input logic [19:0] exp_dac, input logic [19:0] exp_ctrl);
    logic pol, pha, b;
    exp_t e;
    pol = (m >= 2);
    pha = (m == 0) || (m == 3);
    mode     = m;
    sck_drv  = pol;
    ss_drv   = 1'b1;
    mosi_drv = 1'b0;
    cap_word = '0;
    repeat (HALF) @(negedge clk);
    if (push) begin
      e = '{err: exp_err, chk_miso: chk_miso, miso: exp_miso, dac: exp_dac, ctrl: exp_ctrl};
      sb.push_back(e);
    end
    ss_drv = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 24) ? word[23 - i] : 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      if (!pha) begin
        mosi_drv = b;
        repeat (HALF) @(negedge clk);
        cap_word = {cap_word[22:0], miso_v[m]};
        sck_drv  = ~pol;
        repeat (HALF) @(negedge clk);
        sck_drv  = pol;
      end else begin
        sck_drv  = ~pol;
        mosi_drv = b;
        repeat (HALF) @(negedge clk);
        cap_word = {cap_word[22:0], miso_v[m]};
        sck_drv  = pol;
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
    ss_drv = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    mode     = 0;
    sck_drv  = 1'b0;
    ss_drv   = 1'b1;
    mosi_drv = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_miso",       24'(miso_v[0]), 24'h0);
    check("reset_dac",        24'(dac_v[0]),  24'h0);
    check("reset_ctrl",       24'(ctrl_v[0]), 24'h0);
    check("reset_frame_done", 24'(done_v[0]), 24'h0);
    check("reset_frame_err",  24'(err_v[0]),  24'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic write to the DAC register; no read pending so miso stays 0.
    spi_frame(0, 24'h1ABCDE, 24, -1, 1, 0, 1, 24'h000000, 20'hABCDE, 20'h00000);
    // Read DAC back on the following frame.
    spi_frame(0, 24'h900000, 24, -1, 1, 0, 1, 24'h000000, 20'hABCDE, 20'h00000);
    spi_frame(0, 24'h000000, 24, -1, 1, 0, 1, 24'h9ABCDE, 20'hABCDE, 20'h00000);
    // Control write, ignored address 5, then read of address 5 returns zero data.
    spi_frame(0, 24'h212345, 24, -1, 1, 0, 1, 24'h000000, 20'hABCDE, 20'h12345);
    spi_frame(0, 24'h5FFFFF, 24, -1, 1, 0, 1, 24'h000000, 20'hABCDE, 20'h12345);
    spi_frame(0, 24'hD00000, 24, -1, 1, 0, 1, 24'h000000, 20'hABCDE, 20'h12345);
    spi_frame(0, 24'h000000, 24, -1, 1, 0, 1, 24'hD00000, 20'hABCDE, 20'h12345);
    // Short and long frames flag an error and commit nothing.
    spi_frame(0, 24'h1FFFFF, 12, -1, 1, 1, 0, 24'h000000, 20'hABCDE, 20'h12345);
    spi_frame(0, 24'h1FFFFF, 25, -1, 1, 1, 0, 24'h000000, 20'hABCDE, 20'h12345);
    // A truncated frame after a read keeps the read-back pending.
    spi_frame(0, 24'hA00000, 24, -1, 1, 0, 1, 24'h000000, 20'hABCDE, 20'h12345);
    spi_frame(0, 24'h100000, 12, -1, 1, 1, 0, 24'h000000, 20'hABCDE, 20'h12345);
    spi_frame(0, 24'h000000, 24, -1, 1, 0, 1, 24'hA12345, 20'hABCDE, 20'h12345);
    // Reset in the middle of a write frame: no pulse, registers back to reset.
    spi_frame(0, 24'h1FFFFF, 24, 8, 0, 0, 0, 24'h000000, 20'h00000, 20'h00000);
    check("post_reset_dac",  24'(dac_v[0]),  24'h0);
    check("post_reset_ctrl", 24'(ctrl_v[0]), 24'h0);
    spi_frame(0, 24'h100042, 24, -1, 1, 0, 1, 24'h000000, 20'h00042, 20'h00000);
    // Mode sweep: the same write in every CPOL/CPHA combination.
    for (int m = 1; m < 4; m++)
      spi_frame(m, 24'h15A5A5, 24, -1, 1, 0, 1, 24'h000000, 20'h5A5A5, 20'h00000);
    spi_frame(0, 24'h15A5A5, 24, -1, 1, 0, 1, 24'h000000, 20'h5A5A5, 20'h00000);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 24'(sb.size()), 24'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
